// File: rtl/func_sweep_pkg.sv
// Shared definitions for the function-sweep controller.
//   state_t      : sweep FSM states
//   VEC_W        : width of the swept input vector
//   CNT_W        : width of the mismatch counter (holds 0..16)
//   SETTLE_*     : legal range and counter width for the settle parameter
package func_sweep_pkg;

   localparam int unsigned VEC_W      = 4;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned SETTLE_MIN = 1;
   localparam int unsigned SETTLE_MAX = 15;
   localparam int unsigned SETTLE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/func_sweep_cmp.sv
// Sample/compare/record unit for the function sweep.
//   clk, reset  : clock, async active-high reset
//   clr         : clear results at the start of a sweep
//   en          : sample this cycle (FSM in SAMPLE)
//   vec         : vector currently applied to both function units
//   y_a, y_b    : function unit outputs
//   table_a     : captured truth table of y_a
//   mism_cnt    : mismatches seen in the sweep
//   first_fail  : vector of the first mismatch
//   first_valid : first_fail is valid
module func_sweep_cmp
   import func_sweep_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [VEC_W-1:0] vec,
   input  logic             y_a,
   input  logic             y_b,
   output logic [15:0]      table_a,
   output logic [CNT_W-1:0] mism_cnt,
   output logic [VEC_W-1:0] first_fail,
   output logic             first_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 ** VEC_W);

   logic [15:0]      table_d,  table_q;
   logic [CNT_W-1:0] mism_d,   mism_q;
   logic [VEC_W-1:0] ff_d,     ff_q;
   logic             fv_d,     fv_q;

   always_comb begin
      table_d = table_q;
      mism_d  = mism_q;
      ff_d    = ff_q;
      fv_d    = fv_q;
      if (clr) begin
         table_d = '0;
         mism_d  = '0;
         fv_d    = 1'b0;
      end else if (en) begin
         table_d[vec] = y_a;
         if (y_a != y_b) begin
            // saturate rather than wrap
            if (mism_q != CNT_MAX) begin
               mism_d = mism_q + 1'b1;
            end
            if (!fv_q) begin
               ff_d = vec;
               fv_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         table_q <= '0;
         mism_q  <= '0;
         ff_q    <= '0;
         fv_q    <= 1'b0;
      end else begin
         table_q <= table_d;
         mism_q  <= mism_d;
         ff_q    <= ff_d;
         fv_q    <= fv_d;
      end
   end

   assign table_a     = table_q;
   assign mism_cnt    = mism_q;
   assign first_fail  = ff_q;
   assign first_valid = fv_q;

endmodule

// File: rtl/func_sweep_ctrl.sv
// Exhaustive sweep controller comparing two implementations of a function.
//   N_IN        : number of swept inputs (3 or 4)
//   SETTLE      : settle cycles per vector before sampling (1..15)
//   clk, reset  : clock, async active-high reset
//   start/abort : begin / terminate a sweep
//   vec         : vector driven to both function units
//   y_a, y_b    : function unit outputs
//   busy, done  : sweep active / one-cycle completion pulse
//   pass        : last completed sweep had no mismatches
//   mism_cnt, first_fail, first_valid, table_a : sweep results
module func_sweep_ctrl
   import func_sweep_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned SETTLE = 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic [VEC_W-1:0] vec,
   input  logic             y_a,
   input  logic             y_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mism_cnt,
   output logic [VEC_W-1:0] first_fail,
   output logic             first_valid,
   output logic [15:0]      table_a
);

   localparam logic [VEC_W-1:0]    VEC_LAST    = VEC_W'((1 << N_IN) - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

   state_t              state_d,  state_q;
   logic [VEC_W-1:0]    vec_d,    vec_q;
   logic [SETTLE_W-1:0] settle_d, settle_q;
   logic                busy_d,   busy_q;
   logic                done_d,   done_q;
   logic                pass_d,   pass_q;
   logic                clr;
   logic                sample_en;

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      settle_d  = settle_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      clr       = 1'b0;
      sample_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            vec_d = '0;
            if (start && !abort) begin
               state_d  = ST_DRIVE;
               settle_d = '0;
               busy_d   = 1'b1;
               pass_d   = 1'b0;
               clr      = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               state_d  = ST_IDLE;
               vec_d    = '0;
               settle_d = '0;
               busy_d   = 1'b0;
               pass_d   = 1'b0;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               state_d  = ST_IDLE;
               vec_d    = '0;
               settle_d = '0;
               busy_d   = 1'b0;
               pass_d   = 1'b0;
            end else begin
               sample_en = 1'b1;
               if (vec_q == VEC_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  // pass is registered alongside done, so fold in the last sample
                  pass_d  = (mism_cnt == '0) && (y_a == y_b);
               end else begin
                  state_d  = ST_DRIVE;
                  vec_d    = vec_q + 1'b1;
                  settle_d = '0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   func_sweep_cmp u_cmp (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .en          (sample_en),
      .vec         (vec_q),
      .y_a         (y_a),
      .y_b         (y_b),
      .table_a     (table_a),
      .mism_cnt    (mism_cnt),
      .first_fail  (first_fail),
      .first_valid (first_valid)
   );

   assign vec  = vec_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: a 4-input/SETTLE=1 instance and a 3-input/SETTLE=1
// instance, function units modelled as truth tables indexed by vec.
module tb_func_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort;
   logic        sel;
   logic [15:0] tab_a, tab_b;

   logic        start4, abort4, start3, abort3;
   logic [3:0]  vec4, vec3, ff4, ff3;
   logic        busy4, done4, pass4, fv4, busy3, done3, pass3, fv3;
   logic [4:0]  mism4, mism3;
   logic [15:0] ta4, ta3;

   logic [3:0]  o_vec, o_ff;
   logic        o_busy, o_done, o_pass, o_fv;
   logic [4:0]  o_mism;
   logic [15:0] o_tab;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   assign start4 = start & ~sel;
   assign abort4 = abort & ~sel;
   assign start3 = start & sel;
   assign abort3 = abort & sel;

   assign o_vec  = sel ? vec3  : vec4;
   assign o_ff   = sel ? ff3   : ff4;
   assign o_busy = sel ? busy3 : busy4;
   assign o_done = sel ? done3 : done4;
   assign o_pass = sel ? pass3 : pass4;
   assign o_fv   = sel ? fv3   : fv4;
   assign o_mism = sel ? mism3 : mism4;
   assign o_tab  = sel ? ta3   : ta4;

   func_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .abort(abort4), .vec(vec4),
      .y_a(tab_a[vec4]), .y_b(tab_b[vec4]), .busy(busy4), .done(done4),
      .pass(pass4), .mism_cnt(mism4), .first_fail(ff4), .first_valid(fv4),
      .table_a(ta4)
   );

   func_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .abort(abort3), .vec(vec3),
      .y_a(tab_a[vec3]), .y_b(tab_b[vec3]), .busy(busy3), .done(done3),
      .pass(pass3), .mism_cnt(mism3), .first_fail(ff3), .first_valid(fv3),
      .table_a(ta3)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vec"},  32'(o_vec),  0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_done"}, 32'(o_done), 0);
      check({tag, "_pass"}, 32'(o_pass), 0);
      check({tag, "_mism"}, 32'(o_mism), 0);
      check({tag, "_ff"},   32'(o_ff),   0);
      check({tag, "_fv"},   32'(o_fv),   0);
      check({tag, "_tab"},  32'(o_tab),  0);
   endtask

   // Full sweep with expectations derived from the truth tables directly.
   task automatic run_sweep(input bit s, input logic [15:0] ta, input logic [15:0] tb,
                            input bit abort_in_done);
      int unsigned n_in;
      int unsigned settle;
      int unsigned nv;
      int unsigned d_cyc;
      logic [15:0] mask;
      logic [15:0] diff;
      int unsigned exp_m;
      int unsigned exp_ff;
      bit          exp_fv;
      n_in   = s ? 3 : 4;
      settle = 1;
      nv     = 1 << n_in;
      d_cyc  = nv * (settle + 1);
      mask   = (nv == 16) ? 16'hFFFF : 16'h00FF;
      diff   = (ta ^ tb) & mask;
      exp_m  = 0;
      exp_ff = 0;
      exp_fv = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (diff[i]) begin
            exp_m++;
            exp_ff = i;
            exp_fv = 1'b1;
         end
      end
      sel   = s;
      tab_a = ta;
      tab_b = tb;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", 32'(o_busy), 1);
      check("start_vec",  32'(o_vec),  0);
      for (int n = 1; n <= int'(d_cyc) + 2; n++) begin
         @(posedge clk); #1;
         check("done", 32'(o_done), 32'(n == int'(d_cyc)));
         if (n < int'(d_cyc)) begin
            check("vec",  32'(o_vec),  32'(n / int'(settle + 1)));
            check("busy", 32'(o_busy), 1);
         end
         if (n == int'(d_cyc)) begin
            check("end_busy", 32'(o_busy), 1);
            check("end_tab",  32'(o_tab),  32'(ta & mask));
            check("end_mism", 32'(o_mism), exp_m);
            check("end_pass", 32'(o_pass), 32'(exp_m == 0));
            check("end_fv",   32'(o_fv),   32'(exp_fv));
            if (exp_fv) check("end_ff", 32'(o_ff), exp_ff);
            if (abort_in_done) abort = 1'b1;
         end
         if (n == int'(d_cyc) + 1) abort = 1'b0;
         if (n == int'(d_cyc) + 2) begin
            check("idle_busy", 32'(o_busy), 0);
            check("idle_vec",  32'(o_vec),  0);
            check("hold_tab",  32'(o_tab),  32'(ta & mask));
            check("hold_mism", 32'(o_mism), exp_m);
            check("hold_pass", 32'(o_pass), 32'(exp_m == 0));
         end
      end
   endtask

   initial begin
      logic [15:0] par;
      logic [15:0] ra, rb;
      bit          rs;
      par   = 16'h9669;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      sel   = 1'b0;
      tab_a = '0;
      tab_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst4");
      sel = 1'b1; #1;
      check_all_zero("rst3");
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // parity on both units, single mismatch at vec 5, y_b tied low
      run_sweep(1'b0, par, par, 1'b0);
      run_sweep(1'b0, par, par ^ 16'h0020, 1'b0);
      run_sweep(1'b0, par, 16'h0000, 1'b0);

      // abort during the sweep
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         @(posedge clk); #1;
         check("pre_abort_done", 32'(o_done), 0);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", 32'(o_busy), 0);
      check("abort_done", 32'(o_done), 0);
      check("abort_pass", 32'(o_pass), 0);
      check("abort_vec",  32'(o_vec),  0);
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         check("post_abort_done", 32'(o_done), 0);
      end
      run_sweep(1'b0, par, par, 1'b0);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", 32'(o_busy), 0);
      check("sa_vec",  32'(o_vec),  0);
      @(posedge clk); #1;
      check("sa_busy2", 32'(o_busy), 0);

      // start re-pulsed while busy, then asynchronous reset mid-sweep
      tab_a = par;
      tab_b = 16'h0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 19; n++) begin
         @(posedge clk); #1;
         if (n == 5) start = 1'b1;
         if (n == 6) start = 1'b0;
         check("rp_vec",  32'(o_vec),  32'(n / 2));
         check("rp_busy", 32'(o_busy), 1);
      end
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         check("post_rst_done", 32'(o_done), 0);
         check("post_rst_busy", 32'(o_busy), 0);
      end

      // abort asserted while in DONE is ignored
      run_sweep(1'b0, par, par ^ 16'h8001, 1'b1);
      run_sweep(1'b0, par, par, 1'b1);

      // three-input instance, both units constant zero
      run_sweep(1'b1, 16'h0000, 16'h0000, 1'b0);

      // randomized truth tables on both instances
      for (int k = 0; k < 8; k++) begin
         rs = 1'($urandom_range(0, 1));
         ra = 16'($urandom);
         rb = ra ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         run_sweep(rs, ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
